// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, cycle defaults and FSM states
// for the E-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_t;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  function automatic int mdu_cnt_w(
    input int a,
    input int b
  );
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage controller <-> MDU bundle.
// master = decoder/controller side, slave = the MDU.
interface mdu_if;
  import mdu_pkg::*;

  logic        start;
  mdu_op_t     mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;

  modport master (
    output start, mdu_op, rs_val, rt_val,
    input  busy, hi, lo, result
  );

  modport slave (
    input  start, mdu_op, rs_val, rt_val,
    output busy, hi, lo, result
  );

endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning HI/LO.
// Results are computed at accept and committed when the countdown ends.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int CW = mdu_cnt_w(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] LD_MUL = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] LD_DIV = CW'(DIV_CYCLES);

  mdu_state_t    r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [31:0]   r_hi, w_hi_n;
  logic [31:0]   r_lo, w_lo_n;
  logic [31:0]   r_phi, w_phi_n;
  logic [31:0]   r_plo, w_plo_n;
  logic          r_dz, w_dz_n;

  logic signed [63:0] w_sa, w_sb;
  logic [63:0]        w_smul, w_umul;
  logic               w_dz, w_ovf;
  logic [31:0]        w_rt_u;
  logic signed [31:0] w_rs_s, w_rt_s;
  logic signed [31:0] w_sq, w_sr;
  logic [31:0]        w_uq, w_ur;

  logic w_is_mul, w_is_mulu, w_is_div, w_is_divu;
  logic w_is_mthi, w_is_mtlo;

  assign w_sa   = {{32{bus.rs_val[31]}}, bus.rs_val};
  assign w_sb   = {{32{bus.rt_val[31]}}, bus.rt_val};
  assign w_smul = w_sa * w_sb;
  assign w_umul = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

  // Divisors are forced to 1 for /0 and for the signed overflow
  // case; the latter then naturally yields 0x80000000 rem 0.
  assign w_dz   = (bus.rt_val == 32'd0);
  assign w_ovf  = (bus.rs_val == 32'h8000_0000) &&
                  (bus.rt_val == 32'hFFFF_FFFF);
  assign w_rt_u = w_dz ? 32'd1 : bus.rt_val;
  assign w_rs_s = bus.rs_val;
  assign w_rt_s = (w_dz || w_ovf) ? 32'sd1 : bus.rt_val;
  assign w_sq   = w_rs_s / w_rt_s;
  assign w_sr   = w_rs_s % w_rt_s;
  assign w_uq   = bus.rs_val / w_rt_u;
  assign w_ur   = bus.rs_val % w_rt_u;

  assign w_is_mul  = (bus.mdu_op == MDU_MULT);
  assign w_is_mulu = (bus.mdu_op == MDU_MULTU);
  assign w_is_div  = (bus.mdu_op == MDU_DIV);
  assign w_is_divu = (bus.mdu_op == MDU_DIVU);
  assign w_is_mthi = (bus.mdu_op == MDU_MTHI);
  assign w_is_mtlo = (bus.mdu_op == MDU_MTLO);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    w_phi_n   = r_phi;
    w_plo_n   = r_plo;
    w_dz_n    = r_dz;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            w_is_mul: begin
              {w_phi_n, w_plo_n} = w_smul;
              w_dz_n    = 1'b0;
              w_cnt_n   = LD_MUL;
              w_state_n = BUSY;
            end
            w_is_mulu: begin
              {w_phi_n, w_plo_n} = w_umul;
              w_dz_n    = 1'b0;
              w_cnt_n   = LD_MUL;
              w_state_n = BUSY;
            end
            w_is_div: begin
              w_phi_n   = w_sr;
              w_plo_n   = w_sq;
              w_dz_n    = w_dz;
              w_cnt_n   = LD_DIV;
              w_state_n = BUSY;
            end
            w_is_divu: begin
              w_phi_n   = w_ur;
              w_plo_n   = w_uq;
              w_dz_n    = w_dz;
              w_cnt_n   = LD_DIV;
              w_state_n = BUSY;
            end
            w_is_mthi: w_hi_n = bus.rs_val;
            w_is_mtlo: w_lo_n = bus.rs_val;
            default: ;
          endcase
        end
      end
      BUSY: begin
        w_cnt_n = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          if (!r_dz) begin
            w_hi_n = r_phi;
            w_lo_n = r_plo;
          end
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
      r_phi   <= w_phi_n;
      r_plo   <= w_plo_n;
      r_dz    <= w_dz_n;
    end
  end

  // The hazard unit must never present a new op while busy.
  always @(posedge clk) begin
    if (!reset)
      assert (!(bus.start && r_state == BUSY))
        else $warning("mdu: start ignored while busy");
  end

  assign bus.busy   = (r_state == BUSY);
  assign bus.hi     = r_hi;
  assign bus.lo     = r_lo;
  assign bus.result = (bus.mdu_op == MDU_MFHI) ? r_hi :
                      (bus.mdu_op == MDU_MFLO) ? r_lo :
                      32'd0;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for the multiply/divide unit.
// Expected HI/LO pairs are queued at issue and checked at commit.
module tb_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  mdu_if bus();

  mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] sb[$];

  function automatic logic [63:0] model(
    input mdu_op_t     op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] h,
    input logic [31:0] l
  );
    int ia, ib;
    longint p;
    logic [63:0] r;
    ia = a;
    ib = b;
    r  = {h, l};
    case (op)
      MDU_MULT: begin
        p = longint'(ia) * longint'(ib);
        r = p;
      end
      MDU_MULTU: r = {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        if (b == 0) r = {h, l};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          r = {32'd0, 32'h8000_0000};
        else r = {32'(ia % ib), 32'(ia / ib)};
      end
      MDU_DIVU: begin
        if (b != 0) r = {a % b, a / b};
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic issue(
    input mdu_op_t     op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
  endtask

  task automatic wait_commit(input int rem, input string name);
    logic [63:0] exp;
    for (int i = 0; i < rem; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo) begin
        failures++;
        $display("FAIL %s hold c%0d busy=%b hi=%h lo=%h want 1 %h %h",
                 name, i, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      exp = sb.pop_front();
      if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== exp) begin
        failures++;
        $display("FAIL %s commit busy=%b hi=%h lo=%h want 0 %h %h",
                 name, bus.busy, bus.hi, bus.lo, exp[63:32], exp[31:0]);
      end
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
  endtask

  task automatic run_op(
    input mdu_op_t     op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] exp,
    input string       name
  );
    int n;
    n = (op == MDU_MULT || op == MDU_MULTU) ? 5 : 10;
    sb.push_back(exp);
    issue(op, a, b);
    wait_commit(n, name);
  endtask

  task automatic move(input mdu_op_t op, input logic [31:0] v);
    issue(op, v, 32'd0);
    if (op == MDU_MTHI) m_hi = v;
    else m_lo = v;
    checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL move hi=%h lo=%h busy=%b want %h %h 0",
               bus.hi, bus.lo, bus.busy, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.mdu_op = MDU_MFHI;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 ||
        bus.lo !== 32'd0 || bus.result !== 32'd0) begin
      failures++;
      $display("FAIL reset busy=%b hi=%h lo=%h res=%h want 0",
               bus.busy, bus.hi, bus.lo, bus.result);
    end
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset      = 1'b0;
    bus.mdu_op = MDU_NONE;
  endtask

  task automatic test_mult;
    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5,
           64'hFFFF_FFFF_FFFF_FFF1, "mult_neg");
  endtask

  task automatic test_multu;
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2,
           64'h0000_0001_FFFF_FFFE, "multu");
    bus.mdu_op = MDU_MFLO;
    #1;
    checks++;
    if (bus.result !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL mflo result=%h want fffffffe", bus.result);
    end
    bus.mdu_op = MDU_MFHI;
    #1;
    checks++;
    if (bus.result !== 32'h0000_0001) begin
      failures++;
      $display("FAIL mfhi result=%h want 00000001", bus.result);
    end
    bus.mdu_op = mdu_op_t'(4'd9);
    #1;
    checks++;
    if (bus.result !== 32'd0) begin
      failures++;
      $display("FAIL op9 result=%h want 0", bus.result);
    end
    bus.mdu_op = MDU_NONE;
  endtask

  task automatic test_div;
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2,
           64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000, "div_ovf");
    run_op(MDU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h8000_0000_0000_0000, "divu_big");
  endtask

  task automatic test_divzero;
    move(MDU_MTHI, 32'h1234);
    move(MDU_MTLO, 32'h5678);
    run_op(MDU_DIVU, 32'd7, 32'd0,
           64'h0000_1234_0000_5678, "divu_zero");
    run_op(MDU_DIV, 32'hFFFF_FF00, 32'd0,
           64'h0000_1234_0000_5678, "div_zero");
  endtask

  task automatic test_start_busy;
    sb.push_back(64'h0000_0000_0000_000C);
    issue(MDU_MULT, 32'd3, 32'd4);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = MDU_MTLO;
    bus.rs_val = 32'hAAAA;
    repeat (2) @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
    checks++;
    if (bus.lo === 32'hAAAA) begin
      failures++;
      $display("FAIL busy_mtlo lo=%h want not aaaa", bus.lo);
    end
    wait_commit(3, "start_busy");
  endtask

  task automatic test_back_to_back;
    run_op(MDU_MULTU, 32'd1000, 32'd1000,
           64'h0000_0000_000F_4240, "b2b_mul");
    run_op(MDU_DIVU, 32'd1000, 32'd7,
           64'h0000_0006_0000_008E, "b2b_div");
    run_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE,
           64'h0000_0001_FFFF_FFFD, "b2b_sdiv");
  endtask

  task automatic test_random;
    mdu_op_t op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = mdu_op_t'($urandom_range(1, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op(op, a, b, model(op, a, b, m_hi, m_lo), "rand");
    end
  endtask

  task automatic test_reset_mid;
    bit bad;
    move(MDU_MTHI, 32'hCAFE);
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.mdu_op = MDU_MTHI;
    bus.rs_val = 32'h55;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid busy=%b hi=%h lo=%h want 0 0 0",
               bus.busy, bus.hi, bus.lo);
    end
    @(negedge clk);
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
    m_hi = '0;
    m_lo = '0;
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_nocommit busy=%b hi=%h lo=%h want 0 0 0",
               bus.busy, bus.hi, bus.lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divzero();
    test_start_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "tb_mdu timeout");
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the E stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from the E-stage decoder and owns the architectural HI/LO registers. It reports `busy` to the hazard unit. It produces the MFHI/MFLO value that the E→M pipeline register captures as `E_MDU_result`.

## Interface
- `MULT_CYCLES`, default 5: busy length in cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy length in cycles for DIV/DIVU.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  E-stage instruction is an MDU op and is not stalled or flushed.
- `mdu_op`  in  4  operation code; encodings in `mdu_pkg`.
- `rs_val`  in  32  forwarded rs operand (dividend, multiplicand, MTHI/MTLO source).
- `rt_val`  in  32  forwarded rt operand (divisor, multiplier).
- `busy`  out  1  registered; high while a MULT/DIV is in progress.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.
- `result`  out  32  combinational read value: `hi` for MFHI, `lo` for MFLO, 0 for any other op.

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8. Codes 9–15 behave as NONE.
- Accept rule: an op is accepted only when `start`=1 and `busy`=0. If `busy`=1, `start` is ignored entirely: no state change, and a simulation assertion fires. The hazard unit must stall when `start|busy` and the E-stage op is an MDU op.
- **Multiply ops:**
  - MULT: {HI,LO} = signed(rs) × signed(rt), 64-bit result.
  - MULTU: {HI,LO} = unsigned(rs) × unsigned(rt), 64-bit result.
- **Divide ops:**
  - DIV: LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - DIV special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient in LO, unsigned remainder in HI.
  - Divisor 0, either DIV or DIVU: the unit still goes busy for DIV_CYCLES, and HI/LO are left unchanged.
- **Result capture:** the 64-bit result is computed from the operands at acceptance. It is held in internal pending registers. It is committed to HI/LO only when the countdown ends; until then the old HI/LO stay visible.
- **Move and read ops:**
  - MTHI and MTLO write `rs_val` to HI or LO at the accepting edge. They do not raise `busy`.
  - MFHI and MFLO are purely combinational reads. They have no side effect.
- **State machine:**
  - IDLE: on accepting MULT/MULTU, load the counter with MULT_CYCLES and go to BUSY. On accepting DIV/DIVU, load DIV_CYCLES and go to BUSY.
  - BUSY: decrement the counter each cycle. When counter==1, commit the pending result (unless the divisor was zero), clear `busy`, and return to IDLE.
- Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, counter=0, pending registers=0, state=IDLE. `result` follows from `hi`/`lo`.
- **Reset mid-operation:** reset aborts the operation with no commit, and HI/LO become 0 on the reset edge. If `start` is asserted together with `reset`, it is ignored.
- **Busy window:** a MULT is accepted at edge 0. `busy` is 1 after edges 0 through 4 and 0 after edge 5. The new HI/LO are visible right after edge 5, in the same cycle `busy` drops. DIV behaves the same with 10 cycles.
- **Back-to-back:** a new MDU op may be accepted in the first cycle in which `busy`=0, i.e. the cycle immediately after the commit edge.
- **Move ops:** after an MTHI/MTLO accepted at edge 0, the new value is visible on `hi`/`lo`/`result` after edge 0.
- `result` is combinational from `mdu_op` and HI/LO, so there is zero latency into the E/M register.

## Structure
- Package `mdu_pkg` holds:
  - `mdu_op_t` with the op encodings above;
  - the default cycle constants `MDU_MULT_CYCLES`=5 and `MDU_DIV_CYCLES`=10;
  - the state enum IDLE/BUSY.
- The op decoder shares `mdu_op_t` so the controller drives `mdu_op` directly.
- No sub-module; arithmetic uses behavioural `*`, `/` and `%` on 64/32-bit operands inside one module.

## Test plan
- **Signed multiply:** MULT with rs=0xFFFFFFFD (-3) and rt=5 → `busy` high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFF1. HI/LO hold their old values during busy.
- **Unsigned multiply:** MULTU with rs=0xFFFFFFFF and rt=2 → after 5 cycles, HI=0x00000001 and LO=0xFFFFFFFE. Then MFLO → `result`=0xFFFFFFFE combinationally.
- **Signed divide:** DIV with rs=0xFFFFFFF9 (-7) and rt=2 → `busy` high for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF.
  - Follow with DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** MTHI 0x1234, MTLO 0x5678, then DIVU with rs=7 and rt=0 → `busy` high for 10 cycles, and HI=0x1234, LO=0x5678 remain unchanged.
- **Start while busy:** start MULT 3×4, then assert `start` with MTLO 0xAAAA at cycle 2 → MTLO ignored and assertion fires. After 5 cycles LO=12 and HI=0.
- **Reset mid-divide:** start DIV 100/7 and assert `reset` at cycle 4 → next cycle `busy`=0, HI=0, LO=0. No commit occurs at the original completion time.
